arith_result_decoder: RTL and testbench
=======================================

Name: arith_result_decoder

Overview:
Sequential decoder for the arithmetic unit's result bus. It takes the 8-bit result, the status flag and the operation select, and reconstructs the true numeric value from the per-operation encoding. It then converts that value to three BCD digits using an iterative shift-and-add-3 (double-dabble) engine, and drives three seven-segment digit outputs. It sits between the arithmetic unit and the board display.

Parameters:
SEG_ACTIVE_LOW, 1, 1 = segment outputs active-low; 0 = active-high (bitwise inverse of active-low codes).
BLANK_LEADING, 1, 1 = blank leading zero digits; 0 = always show all three digits.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request conversion; sampled only in IDLE
result  input  8  arithmetic unit result bus
flag  input  1  arithmetic unit status flag (carry/borrow/shift-out/remainder)
select  input  2  operation code: 0 add, 1 sub, 2 mul-by-2, 3 div-by-2
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse when new digits are valid
bcd_h  output  4  hundreds digit
bcd_t  output  4  tens digit
bcd_o  output  4  ones digit
negative  output  1  decoded value is negative
half  output  1  decoded value has a .5 fraction
seg_h  output  7  hundreds segments, gfedcba
seg_t  output  7  tens segments, gfedcba
seg_o  output  7  ones segments, gfedcba

Behaviour:
- Reset (asynchronous, any state, including mid-conversion) sets:
  - state = IDLE; busy = 0; done = 0.
  - bcd_h, bcd_t and bcd_o = 0; negative = 0; half = 0.
  - seg_h and seg_t blank.
  - seg_o shows "0" when BLANK_LEADING = 1, and all three digits show "0" when BLANK_LEADING = 0.
- Value decode: result, flag and select are captured in the LOAD cycle into a 9-bit value V plus sign and fraction registers.
  - select 0: V = {flag, result[3:0]}, range 0..31.
  - select 1, flag = 1: V = (~result[3:0] + 1) mod 16, negative = 1.
  - select 1, flag = 0: V = result[3:0], negative = 0.
  - select 2: V = {flag, result[7:0]}, range 0..511.
  - select 3: V = result[7:0], half = flag.
  - negative and half are 0 in every case not listed above.
- FSM states: IDLE, LOAD, SHIFT, DONE.
  - IDLE: busy = 0. start = 1 moves to LOAD next cycle.
  - LOAD: capture and decode the inputs, clear the 12-bit BCD accumulator, load the shift counter with 9. busy = 1.
  - SHIFT: each cycle, first add 3 to every BCD nibble that is >= 5. Then shift {BCD, V} left by 1 and decrement the counter. After the 9th shift, go to DONE.
  - DONE: register the BCD nibbles, negative, half and segments to the outputs. done = 1 for exactly this cycle. Return to IDLE next cycle.
- Timing:
  - start sampled high at edge N: busy rises after edge N+1; done is high after edge N+11; outputs change only at that same edge.
  - Back-to-back: start high during the done cycle is ignored. The earliest accepted start is in the first IDLE cycle after done.
  - start while busy is ignored and not queued.
  - Inputs need only be stable at the LOAD edge; later changes do not affect the conversion in progress.
- Outputs hold their last converted values between conversions.
- Segment codes (active-low, hex, digits 0..9): 40 79 24 30 19 12 02 78 00 10. Blank = 7F.
  - With SEG_ACTIVE_LOW = 0, every code (including blank) is bitwise inverted.
- Leading blanking (BLANK_LEADING = 1):
  - seg_h blank if bcd_h = 0.
  - seg_t blank if bcd_h = 0 and bcd_t = 0.
  - seg_o never blank.
  - BCD outputs are never blanked.
- The BCD engine must handle V = 511 correctly (5, 1, 1); no digit ever exceeds 9.

Test Plan:
- select=0, result=0x0B, flag=1, start pulse: at +11 cycles done=1; bcd=2,7 (hundreds 0); seg_h=7F, seg_t=24, seg_o=78; negative=0.
- select=1, result=0x0D, flag=1: bcd=0,0,3; negative=1; seg_o=30. Then result=0x05, flag=0: bcd=0,0,5; negative=0.
- select=2, result=0xFF, flag=1: V=511 -> bcd=5,1,1; seg_h=12, seg_t=79, seg_o=79. Then result=0x00, flag=0: seg_h=7F, seg_t=7F, seg_o=40.
- select=3, result=0x07, flag=1: bcd=0,0,7; half=1. Then flag=0: half=0, with done exactly 11 cycles after each accepted start.
- Hold start high for 30 cycles with select=0, result=0x03: done pulses at cycles 11 and 24 relative to the first accepted start; busy never drops during a conversion; input changes mid-conversion are ignored.
- Assert rst_n=0 during SHIFT (cycle 5 of a conversion): outputs immediately show reset values; no done pulse. After release, a new start converts normally.

Source files
------------

// File: rtl/arith_result_decoder.sv
// arith_result_decoder: decodes the arithmetic result bus to BCD digits and seven-segment codes
module arith_result_decoder #(
  parameter logic SEG_ACTIVE_LOW = 1'b1,
  parameter logic BLANK_LEADING = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] result,
  input  logic       flag,
  input  logic [1:0] select,
  output logic       busy,
  output logic       done,
  output logic [3:0] bcd_h,
  output logic [3:0] bcd_t,
  output logic [3:0] bcd_o,
  output logic       negative,
  output logic       half,
  output logic [6:0] seg_h,
  output logic [6:0] seg_t,
  output logic [6:0] seg_o
);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic [8:0] v, dec_v;
  logic [11:0] acc, adj;
  logic [3:0] cnt, neg4;
  logic neg_r, half_r;
  function automatic logic [6:0] enc(input logic [3:0] d, input logic blank);
    logic [6:0] c;
    case (d)
      4'd0: c = 7'h40;
      4'd1: c = 7'h79;
      4'd2: c = 7'h24;
      4'd3: c = 7'h30;
      4'd4: c = 7'h19;
      4'd5: c = 7'h12;
      4'd6: c = 7'h02;
      4'd7: c = 7'h78;
      4'd8: c = 7'h00;
      4'd9: c = 7'h10;
      default: c = 7'h7f;
    endcase
    c = blank ? 7'h7f : c;
    return SEG_ACTIVE_LOW ? c : ~c;
  endfunction
  assign neg4 = ~result[3:0] + 4'd1;
  assign dec_v = select == 2'd0 ? {4'b0, flag, result[3:0]} :
                 select == 2'd1 ? {5'b0, flag ? neg4 : result[3:0]} :
                 select == 2'd2 ? {flag, result} : {1'b0, result};
  genvar i;
  for (i = 0; i < 3; i++) begin : g_adj
    assign adj[4*i+3:4*i] = acc[4*i+3:4*i] >= 4'd5 ? acc[4*i+3:4*i] + 4'd3 : acc[4*i+3:4*i];
  end
  // A start arriving while done is still high is dropped so back-to-back requests never overlap the done cycle
  always_comb
    state_n = state == IDLE  ? (start && !done ? LOAD : IDLE) :
              state == LOAD  ? SHIFT :
              state == SHIFT ? (cnt == 4'd1 ? DONE : SHIFT) : IDLE;
  assign busy = state == SHIFT || state == DONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      done <= 1'b0;
      v <= '0;
      acc <= '0;
      cnt <= '0;
      neg_r <= 1'b0;
      half_r <= 1'b0;
      bcd_h <= '0;
      bcd_t <= '0;
      bcd_o <= '0;
      negative <= 1'b0;
      half <= 1'b0;
      seg_h <= enc(4'd0, BLANK_LEADING);
      seg_t <= enc(4'd0, BLANK_LEADING);
      seg_o <= enc(4'd0, 1'b0);
    end else begin
      state <= state_n;
      done <= state == DONE;
      case (state)
        LOAD: begin
          v <= dec_v;
          neg_r <= select == 2'd1 && flag;
          half_r <= select == 2'd3 && flag;
          acc <= '0;
          cnt <= 4'd9;
        end
        SHIFT: begin
          {acc, v} <= {adj[10:0], v, 1'b0};
          cnt <= cnt - 4'd1;
        end
        DONE: begin
          bcd_h <= acc[11:8];
          bcd_t <= acc[7:4];
          bcd_o <= acc[3:0];
          negative <= neg_r;
          half <= half_r;
          seg_h <= enc(acc[11:8], BLANK_LEADING && acc[11:8] == 4'd0);
          seg_t <= enc(acc[7:4], BLANK_LEADING && acc[11:4] == 8'd0);
          seg_o <= enc(acc[3:0], 1'b0);
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_arith_result_decoder.sv
// tb_arith_result_decoder: scoreboard bench for arith_result_decoder with default parameters
module tb_arith_result_decoder;
  logic clk = 0, rst_n = 0, start = 0, flag = 0;
  logic [7:0] result = 0;
  logic [1:0] select = 0;
  logic busy, done, negative, half;
  logic [3:0] bcd_h, bcd_t, bcd_o;
  logic [6:0] seg_h, seg_t, seg_o;
  typedef struct packed {
    logic [3:0] h, t, o;
    logic neg, half;
    logic [6:0] sh, st, so;
  } exp_t;
  exp_t q[$];
  int cmp = 0, bad = 0;
  localparam logic [6:0] TAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  arith_result_decoder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .result(result), .flag(flag), .select(select),
    .busy(busy), .done(done), .bcd_h(bcd_h), .bcd_t(bcd_t), .bcd_o(bcd_o),
    .negative(negative), .half(half), .seg_h(seg_h), .seg_t(seg_t), .seg_o(seg_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish before 500us");
    $fatal(1);
  end

  function automatic exp_t model(input logic [1:0] s, input logic [7:0] r, input logic f);
    exp_t e;
    int val, h, t, o;
    val = s == 0 ? f * 16 + r[3:0] : s == 1 ? (f ? (16 - r[3:0]) % 16 : r[3:0]) : s == 2 ? f * 256 + r : r;
    h = val / 100;
    t = (val / 10) % 10;
    o = val % 10;
    e.h = 4'(h); e.t = 4'(t); e.o = 4'(o);
    e.neg = s == 1 && f;
    e.half = s == 3 && f;
    e.sh = h == 0 ? 7'h7f : TAB[h];
    e.st = (h == 0 && t == 0) ? 7'h7f : TAB[t];
    e.so = TAB[o];
    return e;
  endfunction

  function automatic exp_t observed();
    return {bcd_h, bcd_t, bcd_o, negative, half, seg_h, seg_t, seg_o};
  endfunction

  task automatic scramble();
    result = 8'($urandom);
    flag = 1'($urandom);
    select = 2'($urandom);
  endtask

  task automatic test_reset();
    exp_t z;
    z = '{h: 0, t: 0, o: 0, neg: 0, half: 0, sh: 7'h7f, st: 7'h7f, so: 7'h40};
    rst_n = 0;
    repeat (2) @(negedge clk);
    cmp++; if (observed() !== z) begin bad++; $display("FAIL reset_outputs got %h want %h", observed(), z); end
    cmp++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL reset_busy_done got %b want 00", {busy, done}); end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic convert(input logic [1:0] s, input logic [7:0] r, input logic f, input string name);
    exp_t e;
    int lat;
    q.push_back(model(s, r, f));
    @(negedge clk);
    select = s; result = r; flag = f; start = 1;
    @(negedge clk);
    start = 0;
    lat = 0;
    cmp++; if (busy !== 1'b0) begin bad++; $display("FAIL %s busy_load got %b want 0", name, busy); end
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        cmp++; if (busy !== 1'b1) begin bad++; $display("FAIL %s busy_rise got %b want 1", name, busy); end
      end
      scramble();
    end
    cmp++; if (lat != 11) begin bad++; $display("FAIL %s latency got %0d want 11", name, lat); end
    e = q.pop_front();
    cmp++; if (observed() !== e) begin bad++; $display("FAIL %s outputs got %h want %h", name, observed(), e); end
    @(negedge clk);
    cmp++; if (done !== 1'b0) begin bad++; $display("FAIL %s done_pulse got %b want 0", name, done); end
  endtask

  task automatic test_add();
    convert(0, 8'h0B, 1, "add_27");
    convert(0, 8'hFF, 0, "add_15");
  endtask

  task automatic test_sub();
    convert(1, 8'h0D, 1, "sub_neg3");
    convert(1, 8'h05, 0, "sub_pos5");
    convert(1, 8'h00, 1, "sub_neg0");
  endtask

  task automatic test_mul();
    convert(2, 8'hFF, 1, "mul_511");
    convert(2, 8'h00, 0, "mul_0");
    convert(2, 8'h63, 0, "mul_99");
  endtask

  task automatic test_div();
    convert(3, 8'h07, 1, "div_7_half");
    convert(3, 8'h07, 0, "div_7");
    convert(3, 8'hC8, 0, "div_200");
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int dq[$];
    int exp_done[3] = '{11, 24, 37};
    for (int k = 0; k < 3; k++) q.push_back(model(0, 8'h03, 0));
    @(negedge clk);
    select = 0; result = 8'h03; flag = 0; start = 1;
    @(negedge clk);
    for (int lat = 1; lat <= 45; lat++) begin
      @(negedge clk);
      if (done) begin
        dq.push_back(lat);
        e = q.size() > 0 ? q.pop_front() : '0;
        cmp++; if (observed() !== e) begin bad++; $display("FAIL b2b outputs at %0d got %h want %h", lat, observed(), e); end
      end
      if ((lat >= 1 && lat <= 10) || (lat >= 14 && lat <= 23) || (lat >= 27 && lat <= 36)) begin
        cmp++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b busy at %0d got %b want 1", lat, busy); end
      end
      if (lat == 30) start = 0;
      if ((lat >= 2 && lat <= 11) || (lat >= 15 && lat <= 24) || lat >= 28) scramble();
      else begin select = 0; result = 8'h03; flag = 0; end
    end
    cmp++; if (dq.size() != 3) begin bad++; $display("FAIL b2b done_count got %0d want 3", dq.size()); end
    for (int k = 0; k < 3 && k < dq.size(); k++) begin
      cmp++; if (dq[k] != exp_done[k]) begin bad++; $display("FAIL b2b done_time%0d got %0d want %0d", k, dq[k], exp_done[k]); end
    end
    q.delete();
  endtask

  task automatic test_reset_mid();
    exp_t z;
    bit seen;
    z = '{h: 0, t: 0, o: 0, neg: 0, half: 0, sh: 7'h7f, st: 7'h7f, so: 7'h40};
    @(negedge clk);
    select = 2; result = 8'hFF; flag = 1; start = 1;
    @(negedge clk);
    start = 0;
    repeat (5) @(negedge clk);
    rst_n = 0;
    #1;
    cmp++; if (observed() !== z) begin bad++; $display("FAIL midreset_outputs got %h want %h", observed(), z); end
    cmp++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL midreset_busy_done got %b want 00", {busy, done}); end
    @(negedge clk);
    rst_n = 1;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    cmp++; if (seen) begin bad++; $display("FAIL midreset_no_done got 1 want 0"); end
    convert(2, 8'hFF, 1, "after_reset_511");
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_div();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
